// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//   Parses ASCII commands from the UART receiver byte stream into one-cycle
//   pet-action pulses. Command format: a letter (F P C H S T, either case),
//   then 0-2 decimal digits, then a CR or LF terminator. Every rejected
//   command produces one err_valid pulse with a code.
//
//   Optional build macro: CMD_QUERY_EN. When it is defined, "?" followed by a
//   terminator pulses status_req. When it is undefined, '?' is an unknown
//   character and status_req is tied low.
//
// Ports
//   clk, rst_n     clock and asynchronous active-low reset
//   rx_byte        receiver byte; 0x00 means no byte, otherwise held until
//                  the next start bit
//   is_sleeping    pet sleep state from the stat engine
//   action_valid   one-cycle pulse when an action is accepted
//   action_code    1 F, 2 P, 3 C, 4 H, 5 S, 6 T; holds the last accepted code
//   action_amount  argument 1..MAX_AMOUNT; holds the last accepted amount
//   err_valid      one-cycle pulse when a command is rejected
//   err_code       0 BADCMD, 1 SYNTAX, 2 RANGE, 3 TIMEOUT, 4 BUSY, 5 ASLEEP
//   busy           high while the cooldown counter is non-zero
//   status_req     one-cycle query pulse (CMD_QUERY_EN builds only)
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES  = 27000000,
    parameter int unsigned COOLDOWN_CYCLES = 2700000,
    parameter int unsigned MAX_AMOUNT      = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       is_sleeping,
    output logic       action_valid,
    output logic [2:0] action_code,
    output logic [4:0] action_amount,
    output logic       err_valid,
    output logic [2:0] err_code,
    output logic       busy,
    output logic       status_req
);
    localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CW = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN_CYCLES);
    localparam logic [7:0]    MAX_ARG  = 8'(MAX_AMOUNT);

    localparam logic [2:0] E_BADCMD  = 3'd0;
    localparam logic [2:0] E_SYNTAX  = 3'd1;
    localparam logic [2:0] E_RANGE   = 3'd2;
    localparam logic [2:0] E_TIMEOUT = 3'd3;
    localparam logic [2:0] E_BUSY    = 3'd4;
    localparam logic [2:0] E_ASLEEP  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ARG,
`ifdef CMD_QUERY_EN
        S_QUERY,
`endif
        S_FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    code_q, code_d;
    logic [4:0]    amt_q, amt_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [CW-1:0] cd_q;
    logic          prev_zero;

    logic          detect, is_digit, is_term;
    logic [2:0]    letter_code;
    logic [3:0]    digit_val;
    logic [7:0]    arg_next;
    logic          issue, acc, rej;
    logic [2:0]    rej_code;

    // A byte is new only on the first cycle it appears after a 0x00 cycle.
    assign detect    = prev_zero && (rx_byte != 8'h00);
    assign is_digit  = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
    assign is_term   = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
    assign digit_val = rx_byte[3:0];
    // amt_q never exceeds MAX_AMOUNT here, so 8 bits cannot wrap.
    assign arg_next  = ({3'b000, amt_q} * 8'd10) + {4'h0, digit_val};
    assign busy      = (cd_q != '0);

    always_comb begin
        letter_code = 3'd0;
        case (rx_byte)
            8'h46, 8'h66: letter_code = 3'd1;  // F f
            8'h50, 8'h70: letter_code = 3'd2;  // P p
            8'h43, 8'h63: letter_code = 3'd3;  // C c
            8'h48, 8'h68: letter_code = 3'd4;  // H h
            8'h53, 8'h73: letter_code = 3'd5;  // S s
            8'h54, 8'h74: letter_code = 3'd6;  // T t
            default:      letter_code = 3'd0;
        endcase
    end

`ifdef CMD_QUERY_EN
    logic query_d;
`endif

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        amt_d    = amt_q;
        cnt_d    = cnt_q;
        gap_d    = '0;
        issue    = 1'b0;
        acc      = 1'b0;
        rej      = 1'b0;
        rej_code = E_BADCMD;
`ifdef CMD_QUERY_EN
        query_d  = 1'b0;
`endif
        if (detect) begin
            case (state_q)
                S_IDLE: begin
                    if (letter_code != 3'd0) begin
                        state_d = S_CMD;
                        code_d  = letter_code;
                        amt_d   = 5'd1;
                        cnt_d   = 2'd0;
                    end else if (is_term) begin
                        state_d = S_IDLE;
`ifdef CMD_QUERY_EN
                    end else if (rx_byte == 8'h3F) begin
                        state_d = S_QUERY;
`endif
                    end else begin
                        rej      = 1'b1;
                        rej_code = E_BADCMD;
                        state_d  = S_FLUSH;
                    end
                end
                S_CMD: begin
                    if (is_digit) begin
                        state_d = S_ARG;
                        amt_d   = {1'b0, digit_val};
                        cnt_d   = 2'd1;
                    end else if (is_term) begin
                        issue   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rej      = 1'b1;
                        rej_code = E_SYNTAX;
                        state_d  = S_FLUSH;
                    end
                end
                S_ARG: begin
                    if (is_digit) begin
                        if ((cnt_q == 2'd2) || (arg_next > MAX_ARG)) begin
                            rej      = 1'b1;
                            rej_code = E_RANGE;
                            state_d  = S_FLUSH;
                        end else begin
                            amt_d = arg_next[4:0];
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else if (is_term) begin
                        state_d = S_IDLE;
                        if (amt_q == 5'd0) begin
                            rej      = 1'b1;
                            rej_code = E_RANGE;
                        end else begin
                            issue = 1'b1;
                        end
                    end else begin
                        rej      = 1'b1;
                        rej_code = E_SYNTAX;
                        state_d  = S_FLUSH;
                    end
                end
`ifdef CMD_QUERY_EN
                S_QUERY: begin
                    if (is_term) begin
                        query_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rej      = 1'b1;
                        rej_code = E_SYNTAX;
                        state_d  = S_FLUSH;
                    end
                end
`endif
                S_FLUSH: begin
                    if (is_term) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            // Byte-gap watchdog; an abandoned flush returns to idle quietly.
            if (gap_q == GAP_LAST) begin
                state_d = S_IDLE;
                if (state_q != S_FLUSH) begin
                    rej      = 1'b1;
                    rej_code = E_TIMEOUT;
                end
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end

        if (issue) begin
            if (is_sleeping && (code_q != 3'd5)) begin
                rej      = 1'b1;
                rej_code = E_ASLEEP;
            end else if (busy) begin
                rej      = 1'b1;
                rej_code = E_BUSY;
            end else begin
                acc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            code_q        <= '0;
            amt_q         <= '0;
            cnt_q         <= '0;
            gap_q         <= '0;
            cd_q          <= '0;
            prev_zero     <= 1'b0;
            action_valid  <= 1'b0;
            action_code   <= '0;
            action_amount <= '0;
            err_valid     <= 1'b0;
            err_code      <= '0;
        end else begin
            prev_zero    <= (rx_byte == 8'h00);
            state_q      <= state_d;
            code_q       <= code_d;
            amt_q        <= amt_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            action_valid <= acc;
            err_valid    <= rej;
            if (acc) begin
                cd_q          <= CD_LOAD;
                action_code   <= code_q;
                action_amount <= amt_q;
            end else if (cd_q != '0) begin
                cd_q <= cd_q - CW'(1);
            end
            if (rej) err_code <= rej_code;
        end
    end

`ifdef CMD_QUERY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) status_req <= 1'b0;
        else        status_req <= query_d;
    end
`else
    assign status_req = 1'b0;
`endif

endmodule
